uart_mult_byte_tx: RTL and testbench

- Multi-byte UART transmitter; the return path for the multi-byte UART receiver that feeds the register mapper.
- Takes a payload of up to MAX_BYTES bytes with a single start strobe and serialises it on uart_txd as a framed packet: header, length, payload, checksum.
- Runs in the clk_50M domain; replaces the tied-high uart_txd in the top level for status/ack replies.

---
 rtl/uart_mult_byte_tx.sv | 172 +++++++++++++++++
 tb/tb_uart_mult_byte_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART transmitter: sends HEADER, length, payload and an 8-bit
// additive checksum (length + payload, mod 256) as back-to-back 8N1 bytes.
module uart_mult_byte_tx #(
  parameter int         CLK_FREQ  = 50_000_000,
  parameter int         UART_BPS  = 115200,
  parameter int         MAX_BYTES = 12,
  parameter logic [7:0] HEADER    = 8'hA5
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   tx_start,
  input  logic [3:0]             tx_len,
  input  logic [8*MAX_BYTES-1:0] tx_payload,
  output logic                   uart_txd,
  output logic                   tx_busy,
  output logic                   tx_byte_done,
  output logic                   tx_done,
  output logic                   tx_err
);

  localparam int               BPS_CNT   = CLK_FREQ / UART_BPS;
  localparam int               CNT_W     = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(BPS_CNT - 2);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
  localparam logic [3:0]       MAX_LEN   = 4'(MAX_BYTES);
  localparam logic [3:0]       STOP_IDX  = 4'd9;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_PAY, S_CSUM} frame_state_e;

  function automatic logic [7:0] pick_byte(input logic [8*MAX_BYTES-1:0] p,
                                           input logic [3:0]             idx);
    logic [8*MAX_BYTES-1:0] sh;
    sh = p >> {idx, 3'b000};
    return sh[7:0];
  endfunction

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  frame_state_e           state_q;
  logic [CNT_W-1:0]       baud_q;
  logic [3:0]             bit_q;
  logic [7:0]             byte_q;
  logic [3:0]             len_q;
  logic [3:0]             pay_idx_q;
  logic [7:0]             csum_q;
  logic [8*MAX_BYTES-1:0] payload_q;
  logic                   txd_q;
  logic                   busy_q;
  logic                   byte_done_q;
  logic                   done_q;
  logic                   err_q;

  logic       bit_end_s;
  logic       pre_end_s;
  logic       stop_s;
  logic       len_bad_s;
  logic [7:0] first_pay_s;
  logic [7:0] next_pay_s;

  assign bit_end_s   = (baud_q == BAUD_LAST);
  assign pre_end_s   = (baud_q == BAUD_PRE);
  assign stop_s      = (bit_q == STOP_IDX);
  assign len_bad_s   = (tx_len == 4'd0) || (tx_len > MAX_LEN);
  assign first_pay_s = pick_byte(payload_q, 4'd0);
  assign next_pay_s  = pick_byte(payload_q, pay_idx_q + 4'd1);

  // Frame and byte sequencing; bit 0 is the start bit, 1..8 data, 9 stop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= 4'd0;
      byte_q      <= 8'h00;
      len_q       <= 4'd0;
      pay_idx_q   <= 4'd0;
      csum_q      <= 8'h00;
      payload_q   <= '0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (tx_start) begin
            if (len_bad_s) begin
              err_q <= 1'b1;
            end else begin
              state_q   <= S_HDR;
              len_q     <= tx_len;
              payload_q <= tx_payload;
              csum_q    <= 8'h00;
              byte_q    <= HEADER;
              bit_q     <= 4'd0;
              baud_q    <= '0;
              pay_idx_q <= 4'd0;
              txd_q     <= 1'b0;
              busy_q    <= 1'b1;
            end
          end
        end
        S_HDR, S_LEN, S_PAY, S_CSUM: begin
          // Pulses are set one cycle early so they coincide with the stop bit's last cycle.
          if (stop_s && pre_end_s) begin
            byte_done_q <= 1'b1;
            done_q      <= (state_q == S_CSUM);
          end
          if (!bit_end_s) begin
            baud_q <= baud_q + BAUD_ONE;
          end else begin
            baud_q <= '0;
            if (!stop_s) begin
              bit_q <= bit_q + 4'd1;
              txd_q <= (bit_q == 4'd8) ? 1'b1 : byte_q[bit_q[2:0]];
            end else begin
              bit_q <= 4'd0;
              txd_q <= 1'b0;
              case (state_q)
                S_HDR: begin
                  state_q <= S_LEN;
                  byte_q  <= {4'h0, len_q};
                  csum_q  <= csum_add(csum_q, {4'h0, len_q});
                end
                S_LEN: begin
                  state_q   <= S_PAY;
                  pay_idx_q <= 4'd0;
                  byte_q    <= first_pay_s;
                  csum_q    <= csum_add(csum_q, first_pay_s);
                end
                S_PAY: begin
                  if (pay_idx_q == len_q - 4'd1) begin
                    state_q <= S_CSUM;
                    byte_q  <= csum_q;
                  end else begin
                    pay_idx_q <= pay_idx_q + 4'd1;
                    byte_q    <= next_pay_s;
                    csum_q    <= csum_add(csum_q, next_pay_s);
                  end
                end
                default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  txd_q   <= 1'b1;
                end
              endcase
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign uart_txd     = txd_q;
  assign tx_busy      = busy_q;
  assign tx_byte_done = byte_done_q;
  assign tx_done      = done_q;
  assign tx_err       = err_q;

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Bench for uart_mult_byte_tx: table of frames decoded off the serial line,
// plus sequences for restart-on-done, mid-frame start and mid-frame reset.
module tb_uart_mult_byte_tx;

  localparam int CLK_F = 1_000_000;
  localparam int RATE  = 62_500;
  localparam int BPS   = CLK_F / RATE;
  localparam int MAXB  = 12;

  logic              sys_clk    = 1'b0;
  logic              sys_rst_n  = 1'b1;
  logic              tx_start   = 1'b0;
  logic [3:0]        tx_len     = 4'd0;
  logic [8*MAXB-1:0] tx_payload = '0;
  logic              uart_txd;
  logic              tx_busy;
  logic              tx_byte_done;
  logic              tx_done;
  logic              tx_err;

  uart_mult_byte_tx #(
    .CLK_FREQ (CLK_F),
    .UART_BPS (RATE),
    .MAX_BYTES(MAXB),
    .HEADER   (8'hA5)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .tx_start    (tx_start),
    .tx_len      (tx_len),
    .tx_payload  (tx_payload),
    .uart_txd    (uart_txd),
    .tx_busy     (tx_busy),
    .tx_byte_done(tx_byte_done),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  always #5 sys_clk = ~sys_clk;

  int   passed = 0, total = 0;
  int   cyc = 0, start_cyc = 0, done_cyc = 0;
  int   done_cnt = 0, bd_cnt = 0, err_cnt = 0, bad_edge = 0, idle_viol = 0;
  bit   edge_en = 1'b0, idle_en = 1'b0;
  logic txd_prev = 1'b1;

  typedef struct {
    logic [3:0]  len;
    logic [95:0] payload;
    logic [7:0]  csum;
    logic        err;
  } vec_t;

  vec_t tbl [7];

  // Cycle counter and pulse/edge monitors, sampled 1 time unit after each rising edge.
  always @(posedge sys_clk) begin
    #1;
    cyc++;
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tx_byte_done === 1'b1) bd_cnt++;
    if (tx_err === 1'b1) err_cnt++;
    if (edge_en && (uart_txd !== txd_prev) && (((cyc - start_cyc - 1) % BPS) != 0)) bad_edge++;
    txd_prev = uart_txd;
    if (idle_en && (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 ||
                    tx_byte_done !== 1'b0 || tx_err !== 1'b0)) idle_viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Caller sits on a negedge; returns on the negedge of the first frame cycle.
  task automatic pulse_start(input logic [3:0] len, input logic [95:0] pay);
    tx_len     = len;
    tx_payload = pay;
    tx_start   = 1'b1;
    start_cyc  = cyc;
    @(negedge sys_clk);
    tx_start   = 1'b0;
    tx_len     = ~len;
    tx_payload = ~pay;
  endtask

  task automatic rx_byte(output logic [7:0] b);
    int n;
    b = 8'h00;
    n = 0;
    while (uart_txd !== 1'b0 && n < 40 * BPS) begin
      @(negedge sys_clk);
      n++;
    end
    if (uart_txd !== 1'b0) begin
      check("rx_start_timeout", uart_txd, 0);
      return;
    end
    repeat (BPS / 2) @(negedge sys_clk);
    check("start_bit", uart_txd, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BPS) @(negedge sys_clk);
      b[i] = uart_txd;
    end
    repeat (BPS) @(negedge sys_clk);
    check("stop_bit", uart_txd, 1);
  endtask

  task automatic expect_frame(input logic [3:0] len, input logic [95:0] pay, input logic [7:0] cs);
    logic [7:0] b;
    rx_byte(b);
    check("hdr", b, 8'hA5);
    rx_byte(b);
    check("len_byte", b, {4'h0, len});
    for (int k = 0; k < int'(len); k++) begin
      rx_byte(b);
      check("pay_byte", b, pay[8*k +: 8]);
    end
    rx_byte(b);
    check("csum", b, cs);
  endtask

  task automatic finish_frame(input int len);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 4 * BPS) begin
      @(negedge sys_clk);
      n++;
    end
    check("done_cnt", done_cnt, 1);
    check("frame_span", done_cyc - start_cyc, (len + 3) * 10 * BPS);
    check("byte_done_cnt", bd_cnt, len + 3);
    @(negedge sys_clk);
    check("busy_after_done", tx_busy, 0);
    check("txd_after_done", uart_txd, 1);
    check("bit_edges", bad_edge, 0);
  endtask

  initial begin
    logic [7:0] b;
    int         n;

    tbl[0] = '{4'd2,  96'h3412, 8'h48, 1'b0};
    tbl[1] = '{4'd12, {12{8'hFF}}, 8'h00, 1'b0};
    tbl[2] = '{4'd0,  96'h0, 8'h00, 1'b1};
    tbl[3] = '{4'd13, 96'hAB, 8'h00, 1'b1};
    tbl[4] = '{4'd1,  96'h80, 8'h81, 1'b0};
    tbl[5] = '{4'd3,  {64'hEEEE_EEEE_EEEE_EEEE, 32'h0003_0201}, 8'h09, 1'b0};
    tbl[6] = '{4'd15, 96'h1, 8'h00, 1'b1};

    // Reset values, then a long idle stretch.
    #1 sys_rst_n = 1'b0;
    #2;
    check("rst_txd", uart_txd, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_bd", tx_byte_done, 0);
    check("rst_err", tx_err, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle_en = 1'b1;
    repeat (1000) @(negedge sys_clk);
    idle_en = 1'b0;
    check("idle_quiet", idle_viol, 0);
    edge_en = 1'b1;

    for (int v = 0; v < 7; v++) begin
      done_cnt = 0; bd_cnt = 0; err_cnt = 0; bad_edge = 0;
      @(negedge sys_clk);
      pulse_start(tbl[v].len, tbl[v].payload);
      if (tbl[v].err) begin
        check("err_pulse", tx_err, 1);
        check("err_busy", tx_busy, 0);
        check("err_txd", uart_txd, 1);
        repeat (3) @(negedge sys_clk);
        check("err_once", err_cnt, 1);
        check("err_busy_later", tx_busy, 0);
        check("err_txd_later", uart_txd, 1);
      end else begin
        check("start_busy", tx_busy, 1);
        check("start_bit_latency", uart_txd, 0);
        expect_frame(tbl[v].len, tbl[v].payload, tbl[v].csum);
        finish_frame(int'(tbl[v].len));
        check("no_err", err_cnt, 0);
      end
    end

    // Ignored starts mid-frame and on the done cycle; restart the cycle after.
    done_cnt = 0; bd_cnt = 0; bad_edge = 0;
    @(negedge sys_clk);
    pulse_start(4'd2, 96'h3412);
    rx_byte(b);
    check("b_hdr", b, 8'hA5);
    tx_start = 1'b1; tx_len = 4'd3; tx_payload = 96'h998877;
    @(negedge sys_clk);
    tx_start = 1'b0;
    rx_byte(b);
    check("b_len", b, 8'h02);
    rx_byte(b);
    check("b_p0", b, 8'h12);
    rx_byte(b);
    check("b_p1", b, 8'h34);
    rx_byte(b);
    check("b_csum", b, 8'h48);
    n = 0;
    while (cyc < start_cyc + 50 * BPS && n < 4 * BPS) begin
      @(negedge sys_clk);
      n++;
    end
    check("b_done_at_end", tx_done, 1);
    check("b_bd_with_done", tx_byte_done, 1);
    check("b_busy_at_done", tx_busy, 1);
    tx_start = 1'b1; tx_len = 4'd1; tx_payload = 96'h55;
    @(negedge sys_clk);
    tx_start = 1'b0;
    check("b_busy_after", tx_busy, 0);
    check("b_txd_after", uart_txd, 1);
    check("b_done_cnt", done_cnt, 1);
    check("b_bd_cnt", bd_cnt, 5);
    check("b_span", done_cyc - start_cyc, 50 * BPS);
    done_cnt = 0; bd_cnt = 0;
    pulse_start(4'd2, 96'hBEEF);
    check("restart_busy", tx_busy, 1);
    check("restart_start_bit", uart_txd, 0);
    expect_frame(4'd2, 96'hBEEF, 8'hAF);
    finish_frame(2);

    // Reset during a payload data bit, then a clean frame.
    edge_en = 1'b0;
    done_cnt = 0; bd_cnt = 0;
    @(negedge sys_clk);
    pulse_start(4'd3, 96'hC35A00);
    n = 0;
    while (cyc < start_cyc + 23 * BPS + 3 && n < 30 * BPS) begin
      @(negedge sys_clk);
      n++;
    end
    check("c_pay_bit_low", uart_txd, 0);
    check("c_busy_mid", tx_busy, 1);
    sys_rst_n = 1'b0;
    #1;
    check("c_rst_txd_now", uart_txd, 1);
    check("c_rst_busy_now", tx_busy, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (30 * BPS) @(negedge sys_clk);
    check("c_no_done", done_cnt, 0);
    check("c_bd_before_rst", bd_cnt, 2);
    check("c_idle_txd", uart_txd, 1);
    check("c_idle_busy", tx_busy, 0);
    done_cnt = 0; bd_cnt = 0; bad_edge = 0;
    edge_en = 1'b1;
    pulse_start(4'd3, 96'hC35A00);
    check("c_restart_bit", uart_txd, 0);
    expect_frame(4'd3, 96'hC35A00, 8'h20);
    finish_frame(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
